// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter and sequencer sharing one multi-cycle FP divider among NREQ requesters.
// One operation in flight; stale divider done is blanked after load; timeout yields an error response.
module fp_div_arbiter #(
  parameter int unsigned FPWID      = 64,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned IDW        = $clog2(NREQ),
  parameter int unsigned DONE_BLANK = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*FPWID-1:0]  req_a,
  input  logic [NREQ*FPWID-1:0]  req_b,
  input  logic [NREQ*3-1:0]      req_rm,
  output logic                   div_ld,
  output logic [FPWID-1:0]       div_a,
  output logic [FPWID-1:0]       div_b,
  output logic [2:0]             div_rm,
  input  logic                   div_done,
  input  logic [FPWID-1:0]       div_o,
  input  logic                   div_ovf,
  input  logic                   div_unf,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [FPWID-1:0]       rsp_o,
  output logic [2:0]             rsp_flags,
  output logic                   busy
);

  localparam int unsigned CNT_MAX = (TIMEOUT > DONE_BLANK) ? TIMEOUT : DONE_BLANK;
  localparam int unsigned CNT_LOG = $clog2(CNT_MAX + 1);
  localparam int unsigned CW      = (CNT_LOG > 8) ? CNT_LOG : 8;

  typedef enum logic [2:0] {IDLE, ISSUE, BLANK, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [IDW-1:0]    rr_ptr, rr_ptr_nx;
  logic              grant_any;
  logic [IDW-1:0]    win;
  int unsigned       srch_idx;
  logic [FPWID-1:0]  win_a, win_b;
  logic [2:0]        win_rm;
  logic              div_ld_nx, rsp_valid_nx, busy_nx;
  logic [FPWID-1:0]  div_a_nx, div_b_nx, rsp_o_nx;
  logic [2:0]        div_rm_nx, rsp_flags_nx;
  logic [IDW-1:0]    rsp_id_nx;

  // First requesting slot at or after rr_ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    win       = '0;
    srch_idx  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      srch_idx = (32'(rr_ptr) + i) % NREQ;
      if (!grant_any && req_valid[IDW'(srch_idx)]) begin
        grant_any = 1'b1;
        win       = IDW'(srch_idx);
      end
    end
  end

  always_comb begin
    win_a  = '0;
    win_b  = '0;
    win_rm = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        win_a  = req_a[i*FPWID +: FPWID];
        win_b  = req_b[i*FPWID +: FPWID];
        win_rm = req_rm[i*3 +: 3];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      div_ld    <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      div_rm    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_o     <= '0;
      rsp_flags <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rr_ptr    <= rr_ptr_nx;
      div_ld    <= div_ld_nx;
      div_a     <= div_a_nx;
      div_b     <= div_b_nx;
      div_rm    <= div_rm_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_id    <= rsp_id_nx;
      rsp_o     <= rsp_o_nx;
      rsp_flags <= rsp_flags_nx;
      busy      <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant_any) state_nx = ISSUE;
      ISSUE:   state_nx = BLANK;
      BLANK:   if (cnt == CW'(DONE_BLANK - 1)) state_nx = WAIT;
      WAIT:    if (div_done || cnt == CW'(TIMEOUT)) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Accept strobe, datapath captures and next values of the registered outputs.
  always_comb begin
    req_ready    = '0;
    cnt_nx       = cnt;
    rr_ptr_nx    = rr_ptr;
    div_a_nx     = div_a;
    div_b_nx     = div_b;
    div_rm_nx    = div_rm;
    rsp_id_nx    = rsp_id;
    rsp_o_nx     = rsp_o;
    rsp_flags_nx = rsp_flags;
    div_ld_nx    = (state_nx == ISSUE);
    rsp_valid_nx = (state_nx == RESP);
    busy_nx      = (state_nx != IDLE);
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          if (rst_n) req_ready = NREQ'(1) << win;
          div_a_nx  = win_a;
          div_b_nx  = win_b;
          div_rm_nx = win_rm;
          rsp_id_nx = win;
        end
      end
      ISSUE: cnt_nx = '0;
      BLANK: begin
        if (cnt == CW'(DONE_BLANK - 1)) cnt_nx = '0;
        else                             cnt_nx = cnt + CW'(1);
      end
      WAIT: begin
        if (div_done) begin
          rsp_o_nx     = div_o;
          rsp_flags_nx = {1'b0, div_ovf, div_unf};
        end else if (cnt == CW'(TIMEOUT)) begin
          rsp_o_nx     = '0;
          rsp_flags_nx = 3'b100;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) rr_ptr_nx = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Self-checking bench for fp_div_arbiter: vector table, hand sequences and randomized traffic
// against a round-robin / latency reference model and a behavioural divider.
module tb_fp_div_arbiter;

  localparam int NREQ  = 4;
  localparam int DB    = 3;
  localparam int TO    = 24;
  localparam int TO_T  = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        req_valid, req_ready;
  logic [255:0]      req_a, req_b;
  logic [11:0]       req_rm;
  logic              div_ld, div_done, div_ovf, div_unf;
  logic [63:0]       div_a, div_b, div_o;
  logic [2:0]        div_rm;
  logic              rsp_valid, rsp_ready, busy;
  logic [1:0]        rsp_id;
  logic [63:0]       rsp_o;
  logic [2:0]        rsp_flags;

  logic [3:0]        t_req_valid, t_req_ready;
  logic              t_div_ld, t_rsp_valid, t_rsp_ready, t_busy;
  logic [63:0]       t_div_a, t_div_b, t_rsp_o;
  logic [2:0]        t_div_rm, t_rsp_flags;
  logic [1:0]        t_rsp_id;

  logic [63:0]       opa [NREQ];
  logic [63:0]       opb [NREQ];
  logic [2:0]        oprm[NREQ];

  int n_checks = 0;
  int n_errors = 0;
  int ptr      = 0;
  int k        = 0;
  int m_lat    = 0;
  int m_stale  = 0;

  always #5 clk = ~clk;

  fp_div_arbiter #(.FPWID(64), .NREQ(NREQ), .IDW(2), .DONE_BLANK(DB), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
    .div_ld(div_ld), .div_a(div_a), .div_b(div_b), .div_rm(div_rm),
    .div_done(div_done), .div_o(div_o), .div_ovf(div_ovf), .div_unf(div_unf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_o(rsp_o),
    .rsp_flags(rsp_flags), .busy(busy)
  );

  // Second instance with a short timeout and a divider that never completes.
  fp_div_arbiter #(.FPWID(64), .NREQ(NREQ), .IDW(2), .DONE_BLANK(DB), .TIMEOUT(TO_T)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
    .div_ld(t_div_ld), .div_a(t_div_a), .div_b(t_div_b), .div_rm(t_div_rm),
    .div_done(1'b0), .div_o(64'h0), .div_ovf(1'b0), .div_unf(1'b0),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_id(t_rsp_id), .rsp_o(t_rsp_o),
    .rsp_flags(t_rsp_flags), .busy(t_busy)
  );

  function automatic logic [63:0] fdiv(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) / $bitstoreal(b));
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*64 +: 64] = opa[i];
      req_b[i*64 +: 64] = opb[i];
      req_rm[i*3 +: 3]  = oprm[i];
    end
  end

  // Divider model: k counts cycles since ld; done is high for 'stale' cycles, then from k = lat on.
  always @(posedge clk) begin
    if (div_ld) k <= 1;
    else if (k != 0 && k < 1000) k <= k + 1;
  end
  assign div_o    = fdiv(div_a, div_b);
  assign div_done = (k != 0) && ((k <= m_stale) || (m_lat != 0 && k >= m_lat));

  typedef struct {
    logic [3:0] mask;
    int         lat;
    int         stale;
    logic       ovf;
    logic       unf;
    int         rdy;
    int         exp_id;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] m, input int p);
    int idx;
    for (int i = 0; i < NREQ; i++) begin
      idx = (p + i) % NREQ;
      if (m[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic bit is_timeout(input int lat, input int to);
    return (lat == 0) || (lat > DB + 1 + to);
  endfunction

  // Cycles from accept to first rsp_valid.
  function automatic int exp_cycles(input int lat, input int to);
    if (is_timeout(lat, to)) return DB + 3 + to;
    if (lat <= DB + 1)       return DB + 3;
    return lat + 2;
  endfunction

  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++) begin
      opa[i]  = $realtobits(real'($urandom_range(1, 1000)));
      opb[i]  = $realtobits(real'($urandom_range(1, 1000)));
      oprm[i] = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic run_txn(input logic [3:0] mask, input int lat, input int stale, input logic ovf,
                         input logic unf, input int rdy, input int exp_id);
    int          n, exp_n;
    bit          seen, bad_ld, bad_hold, bad_busy;
    logic [63:0] exp_q;
    logic [2:0]  exp_f;
    exp_n = exp_cycles(lat, TO);
    if (is_timeout(lat, TO)) begin
      exp_q = '0;
      exp_f = 3'b100;
    end else begin
      exp_q = fdiv(opa[exp_id], opb[exp_id]);
      exp_f = {1'b0, ovf, unf};
    end
    m_lat = lat; m_stale = stale; div_ovf = ovf; div_unf = unf;
    req_valid = mask;
    #1;
    check("grant", req_ready, 4'b0001 << exp_id);
    n = 0; seen = 0; bad_ld = 0; bad_hold = 0; bad_busy = 0;
    while (!seen && n < exp_n + 4) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_valid = '0;
        check("div_ld", div_ld, 1);
        check("div_rm", div_rm, oprm[exp_id]);
      end else if (div_ld !== 1'b0) bad_ld = 1;
      if (div_a !== opa[exp_id] || div_b !== opb[exp_id]) bad_hold = 1;
      if (busy !== 1'b1 || req_ready !== 4'b0) bad_busy = 1;
      if (rsp_valid === 1'b1) seen = 1;
    end
    check("rsp_cycle", n, exp_n);
    check("rsp_id", rsp_id, exp_id);
    check("rsp_o", rsp_o, exp_q);
    check("rsp_flags", rsp_flags, exp_f);
    for (int i = 0; i < rdy; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_o !== exp_q || rsp_flags !== exp_f)
        bad_hold = 1;
      if (busy !== 1'b1 || req_ready !== 4'b0) bad_busy = 1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", {rsp_valid, busy}, 2'b00);
    check("div_ld_once", bad_ld, 0);
    check("hold_stable", bad_hold, 0);
    check("busy_no_ready", bad_busy, 0);
    ptr = (exp_id + 1) % NREQ;
  endtask

  initial begin
    int grants[5];
    int ng, n, idx;
    bit bad;
    int r_lat, r_id;
    logic [3:0] r_mask;

    tbl[0]  = '{4'b0100, 20, 0, 1'b0, 1'b0, 0, 2};
    tbl[1]  = '{4'b1111, 15, 3, 1'b0, 1'b0, 0, 3};
    tbl[2]  = '{4'b0110,  5, 0, 1'b1, 1'b0, 7, 1};
    tbl[3]  = '{4'b0111,  2, 0, 1'b0, 1'b1, 0, 2};
    tbl[4]  = '{4'b0011,  0, 0, 1'b0, 1'b0, 2, 0};
    tbl[5]  = '{4'b1001,  4, 1, 1'b1, 1'b1, 1, 3};
    tbl[6]  = '{4'b1000, 28, 0, 1'b0, 1'b0, 0, 3};
    tbl[7]  = '{4'b0001, 27, 0, 1'b1, 1'b0, 0, 0};
    tbl[8]  = '{4'b1111,  6, 0, 1'b0, 1'b0, 3, 1};
    tbl[9]  = '{4'b1100, 29, 0, 1'b0, 1'b0, 0, 2};
    tbl[10] = '{4'b0001,  3, 0, 1'b0, 1'b1, 0, 0};

    randomize_ops();
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1; t_req_valid = '0; t_rsp_ready = 1'b0;
    div_ovf = 1'b0; div_unf = 1'b0; m_lat = 5; m_stale = 0;
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_div_ld", div_ld, 0);
    check("rst_div_a", div_a, 0);
    check("rst_div_b", div_b, 0);
    check("rst_div_rm", div_rm, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_o", rsp_o, 0);
    check("rst_rsp_flags", rsp_flags, 0);
    check("rst_busy", busy, 0);

    // Fairness: all requesters held valid from reset.
    rst_n = 1'b1;
    #1;
    ng = 0;
    for (int c = 0; c < 300 && ng < 5; c++) begin
      if (req_ready != 4'b0) begin
        idx = -1;
        for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) idx = i;
        grants[ng] = idx;
        ng++;
      end
      @(negedge clk);
    end
    check("fair_count", ng, 5);
    for (int i = 0; i < 5; i++) check($sformatf("fair_grant%0d", i), grants[i], i % NREQ);
    req_valid = '0;
    for (int c = 0; c < 60 && busy; c++) @(negedge clk);
    rsp_ready = 1'b0;

    // Timeout on the short-timeout instance, then the next request is accepted.
    t_req_valid = 4'b0010;
    #1;
    check("to_grant", t_req_ready, 4'b0010);
    n = 0;
    while (t_rsp_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
      if (n == 1) t_req_valid = '0;
    end
    check("to_rsp_cycle", n, DB + 3 + TO_T);
    check("to_rsp_id", t_rsp_id, 1);
    check("to_rsp_o", t_rsp_o, 0);
    check("to_rsp_flags", t_rsp_flags, 3'b100);
    t_rsp_ready = 1'b1;
    @(negedge clk);
    t_rsp_ready = 1'b0;
    check("to_rsp_drop", t_rsp_valid, 0);
    t_req_valid = 4'b0011;
    #1;
    check("to_next_grant", t_req_ready, 4'b0001);
    @(negedge clk);
    t_req_valid = '0;
    check("to_next_ld", t_div_ld, 1);
    check("to_next_a", t_div_a, opa[0]);

    // Fresh start for the vector table.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr = 0;
    for (int i = 0; i < 11; i++) begin
      randomize_ops();
      if (i == 0) begin
        opa[2] = 64'h4000000000000000;
        opb[2] = 64'h3FF0000000000000;
      end
      run_txn(tbl[i].mask, tbl[i].lat, tbl[i].stale, tbl[i].ovf, tbl[i].unf, tbl[i].rdy,
              tbl[i].exp_id);
    end

    // Reset in the middle of WAIT abandons the division.
    randomize_ops();
    m_lat = 12; m_stale = 0;
    req_valid = 4'hF;
    #1;
    check("mid_grant", req_ready, 4'b0001 << rr_pick(4'hF, ptr));
    repeat (8) @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_req_ready", req_ready, 0);
    check("mid_div_ld", div_ld, 0);
    check("mid_div_a", div_a, 0);
    check("mid_div_b", div_b, 0);
    check("mid_div_rm", div_rm, 0);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_rsp_id", rsp_id, 0);
    check("mid_rsp_o", rsp_o, 0);
    check("mid_rsp_flags", rsp_flags, 0);
    check("mid_busy", busy, 0);
    rst_n = 1'b1;
    ptr = 0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    check("mid_no_rsp", bad, 0);
    randomize_ops();
    run_txn(4'hF, 5, 0, 1'b0, 1'b0, 0, rr_pick(4'hF, ptr));

    // Randomized traffic against the reference model.
    for (int t = 0; t < 25; t++) begin
      randomize_ops();
      r_mask = 4'($urandom_range(1, 15));
      r_lat  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
      r_id   = rr_pick(r_mask, ptr);
      run_txn(r_mask, r_lat, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), r_id);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_div_arbiter.md
# fp_div_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle floating-point divider (`fpDividenr`) among NREQ requesters. It accepts one operand pair at a time and pulses the divider's `ld`. It blanks the divider's stale `done`, waits for completion or timeout, and returns the rounded result with the requester ID over a valid/ready response channel. It sits between the issue logic of the FP unit and the divider instance.

## Interface
- `FPWID`, 64, operand/result width; passed through to the divider.
- `NREQ`, 4, number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`, requester ID width.
- `DONE_BLANK`, 3, cycles after `div_ld` during which `div_done` is ignored; covers the divider's `done` deassert latency.
- `TIMEOUT`, 255, maximum wait cycles after blanking before an error response.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  NREQ  per-requester request.
- `req_ready`  out  NREQ  one-hot accept; a request transfers when `req_valid[i] & req_ready[i]`.
- `req_a`, `req_b`  in  NREQ*FPWID  packed operands; slot i = bits [i*FPWID +: FPWID].
- `req_rm`  in  NREQ*3  packed rounding modes.
- `div_ld`  out  1  one-cycle load pulse to the divider.
- `div_a`, `div_b`  out  FPWID  registered operands held stable from load to completion.
- `div_rm`  out  3  registered rounding mode, held through completion.
- `div_done`  in  1  divider done.
- `div_o`  in  FPWID  divider result.
- `div_ovf`, `div_unf`  in  1  divider overflow and underflow flags.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accepted.
- `rsp_id`  out  IDW  originating requester.
- `rsp_o`  out  FPWID  quotient; 0 on timeout.
- `rsp_flags`  out  3  {timeout, overflow, underflow}.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, BLANK, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is set, select the winner by round-robin: the first set bit at or after `rr_ptr`, searching upward and wrapping.
  - `req_ready[winner]` is asserted combinationally in this cycle only.
  - Latch the winner's a/b/rm into `div_*` and the winner index into `rsp_id`, then go to ISSUE.
  - `req_ready` is 0 in every other state.
- **ISSUE**
  - `div_ld` = 1 for exactly this cycle.
  - Clear `cnt`, then go to BLANK.
- **BLANK**
  - Count DONE_BLANK cycles; `div_done` is ignored throughout.
  - Then clear `cnt` and go to WAIT.
- **WAIT**
  - On `div_done` = 1: capture `div_o` into `rsp_o` and set `rsp_flags` = {0, `div_ovf`, `div_unf`}. Go to RESP.
  - Otherwise increment `cnt`. When `cnt` == TIMEOUT, set `rsp_o` = 0 and `rsp_flags` = 3'b100, then go to RESP.
- **RESP**
  - `rsp_valid` = 1, and `rsp_*` are held stable until `rsp_ready`.
  - On handshake: `rr_ptr` ← (`rsp_id` + 1) mod NREQ, then go to IDLE.
- One request is in flight at a time. Back-to-back requests are separated by one IDLE cycle after the response handshake.
- `cnt` is 8 bits wide minimum, sized as `$clog2(max(TIMEOUT, DONE_BLANK) + 1)`.
- `rr_ptr` changes only on a response handshake, including timeout responses. Wrap from NREQ-1 goes to 0.
- `req_valid` deasserting in a state other than IDLE has no effect. Requesters must hold `req_valid` and operands until accepted.

## Timing
- Reset (`rst_n` = 0 at a clock edge) forces the following; reset mid-operation abandons the in-flight division:
  - State: IDLE.
  - Outputs driven to 0: `req_ready`, `div_ld`, `div_a`, `div_b`, `div_rm`, `rsp_valid`, `rsp_id`, `rsp_o`, `rsp_flags`, `busy`.
  - Internal: `rr_ptr` = 0, `cnt` = 0.
- Accept in cycle T; `div_ld` high in T+1; blanking covers T+2..T+1+DONE_BLANK.
- `div_done` is first sampled in cycle T+2+DONE_BLANK. If it is high there, `rsp_valid` rises at T+3+DONE_BLANK.
- Timeout: `rsp_valid` rises at T+3+DONE_BLANK+TIMEOUT.
- When `rsp_ready` is held high, `rsp_valid` lasts exactly one cycle. The next accept is possible in the cycle after that handshake.
- Ties are resolved only by `rr_ptr`; no requester is skipped while it has `req_valid` asserted.

## Test plan
- **Single request:** req 2 with a=0x4000000000000000 (2.0), b=0x3FF0000000000000 (1.0). Divider model returns done after 20 cycles.
  - Required: `div_ld` is one cycle, `div_a`/`div_b` stay stable through completion.
  - Required: `rsp_id` = 2, `rsp_o` = 0x4000000000000000, `rsp_flags` = 0.
- **Fairness:** all four `req_valid` are held high from reset.
  - Required: grant order is 0, 1, 2, 3, 0, and `rr_ptr` wraps from 3 to 0.
- **Stale done:** divider model keeps `done` = 1 for 3 cycles after `ld`, then low, then high at cycle 15.
  - Required: the response is taken only from the cycle-15 `done`; no early `rsp_valid`.
- **Timeout:** with TIMEOUT = 10, `div_done` is never asserted after `ld`.
  - Required: `rsp_valid` at T+3+DONE_BLANK+10, `rsp_o` = 0, `rsp_flags` = 3'b100, and the arbiter then accepts the next request.
- **Backpressure:** hold `rsp_ready` = 0 for 7 cycles.
  - Required: `rsp_*` are held stable, `req_ready` stays 0, and `busy` stays 1.
  - Required: after the handshake, the next grant starts from `rsp_id` + 1.
- **Reset mid-WAIT:** drive `rst_n` low for one cycle.
  - Required: all outputs are 0 on the following cycle, `rr_ptr` = 0, and no response is produced for the abandoned request.
